// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the fetch stage.
//
// Holds the fetch PC and drives the instruction-memory address/enable.
// Handles pipeline stall, instruction-memory backpressure, flush redirects
// (highest priority) and taken branches. A branch that resolves while the
// PC cannot advance is latched in a pending register and applied at the
// next advance, so it is never lost.
//
// Ports:
//   clk                 clock, rising edge
//   rst                 synchronous reset, active-high
//   stall_i             pipeline stall, PC holds
//   fetch_ready_i       instruction memory accepts pc_o this cycle
//   branch_flag_i       branch/jump resolved taken this cycle
//   branch_target_i     branch/jump target
//   flush_i             exception/eret flush request
//   flush_target_i      flush redirect target
//   pc_o                current fetch address (registered)
//   pc_seq_o            pc_o + INST_BYTES (combinational, wraps)
//   ce_o                instruction memory enable (registered)
//   redirect_pending_o  a branch target is latched and not yet applied
//   misalign_o          pc_o was loaded from a misaligned target
module pc_gen #(
    parameter int unsigned ADDR_W     = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned INST_BYTES = 4,
    parameter bit          ALIGN_CHK  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              fetch_ready_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_target_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_seq_o,
    output logic              ce_o,
    output logic              redirect_pending_o,
    output logic              misalign_o
);

    // Width of the alignment field; forced to at least 1 so the slice below
    // stays legal when INST_BYTES == 1 (the check is disabled in that case).
    localparam int unsigned LSB_W = (INST_BYTES > 1) ? $clog2(INST_BYTES) : 1;
    localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(INST_BYTES);
    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic              ce_q, ce_d;
    logic              pend_q, pend_d;
    logic              mis_q, mis_d;
    logic              adv;

    function automatic logic is_misaligned(input logic [ADDR_W-1:0] t);
        if (!ALIGN_CHK || INST_BYTES == 1) return 1'b0;
        return |t[LSB_W-1:0];
    endfunction

    assign adv = ce_q & ~stall_i & fetch_ready_i;

    always_comb begin
        pc_d   = pc_q;
        tgt_d  = tgt_q;
        ce_d   = 1'b1;      // enable rises on the first edge after reset and stays up
        pend_d = pend_q;
        mis_d  = mis_q;
        // While ce_q is still 0 (start-up edge) only the enable changes.
        if (ce_q) begin
            if (flush_i) begin
                pc_d   = flush_target_i;
                pend_d = 1'b0;
                mis_d  = is_misaligned(flush_target_i);
            end else if (adv && branch_flag_i) begin
                // A live branch is younger than any pending target.
                pc_d   = branch_target_i;
                pend_d = 1'b0;
                mis_d  = is_misaligned(branch_target_i);
            end else if (adv && pend_q) begin
                pc_d   = tgt_q;
                pend_d = 1'b0;
                mis_d  = is_misaligned(tgt_q);
            end else if (adv) begin
                pc_d  = pc_q + STEP;
                mis_d = 1'b0;
            end else if (branch_flag_i) begin
                pend_d = 1'b1;
                tgt_d  = branch_target_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= RST_PC;
            tgt_q  <= '0;
            ce_q   <= 1'b0;
            pend_q <= 1'b0;
            mis_q  <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            tgt_q  <= tgt_d;
            ce_q   <= ce_d;
            pend_q <= pend_d;
            mis_q  <= mis_d;
        end
    end

    assign pc_o               = pc_q;
    assign pc_seq_o           = pc_q + STEP;
    assign ce_o               = ce_q;
    assign redirect_pending_o = pend_q;
    assign misalign_o         = mis_q;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: two instances (32-bit and 16-bit address) share the
// stimulus; a reference model of the redirect rules tracks each one and
// every cycle's outputs are compared. Directed sequences from the plan are
// followed by a randomized phase.
module tb_pc_gen;
    logic        clk = 1'b0;
    logic        rst, stall, ready, br, fl;
    logic [31:0] br_t, fl_t;

    logic [31:0] pc_a, seq_a;
    logic        ce_a, pend_a, mis_a;
    logic [15:0] pc_b, seq_b;
    logic        ce_b, pend_b, mis_b;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pc_gen #(.ADDR_W(32), .RESET_PC(32'hBFC0_0000), .INST_BYTES(4), .ALIGN_CHK(1'b1)) u_a (
        .clk(clk), .rst(rst), .stall_i(stall), .fetch_ready_i(ready),
        .branch_flag_i(br), .branch_target_i(br_t),
        .flush_i(fl), .flush_target_i(fl_t),
        .pc_o(pc_a), .pc_seq_o(seq_a), .ce_o(ce_a),
        .redirect_pending_o(pend_a), .misalign_o(mis_a));

    pc_gen #(.ADDR_W(16), .RESET_PC(32'hBFC0_0000), .INST_BYTES(4), .ALIGN_CHK(1'b1)) u_b (
        .clk(clk), .rst(rst), .stall_i(stall), .fetch_ready_i(ready),
        .branch_flag_i(br), .branch_target_i(br_t[15:0]),
        .flush_i(fl), .flush_target_i(fl_t[15:0]),
        .pc_o(pc_b), .pc_seq_o(seq_b), .ce_o(ce_b),
        .redirect_pending_o(pend_b), .misalign_o(mis_b));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: one entry per instance (0 = 32-bit, 1 = 16-bit).
    logic [63:0] m_pc[2], m_tgt[2], m_mask[2];
    bit          m_ce[2], m_pend[2], m_mis[2];

    function automatic void m_load(int k, logic [63:0] t);
        m_pc[k]   = t & m_mask[k];
        m_pend[k] = 1'b0;
        m_mis[k]  = (t[1:0] != 2'b00);
    endfunction

    function automatic void m_step(int k);
        bit go;
        go = m_ce[k] && !stall && ready;
        if (rst) begin
            m_pc[k] = 64'hBFC0_0000 & m_mask[k];
            m_tgt[k] = 0; m_ce[k] = 0; m_pend[k] = 0; m_mis[k] = 0;
        end else if (!m_ce[k]) begin
            m_ce[k] = 1'b1;
        end else if (fl) begin
            m_load(k, 64'(fl_t));
        end else if (go && br) begin
            m_load(k, 64'(br_t));
        end else if (go && m_pend[k]) begin
            m_load(k, m_tgt[k]);
        end else if (go) begin
            m_pc[k]  = (m_pc[k] + 4) & m_mask[k];
            m_mis[k] = 1'b0;
        end else if (br) begin
            m_pend[k] = 1'b1;
            m_tgt[k]  = 64'(br_t) & m_mask[k];
        end
    endfunction

    // One clock: advance the model with the inputs seen at the edge, then
    // compare both instances shortly after the edge.
    task automatic cyc();
        @(posedge clk);
        m_step(0);
        m_step(1);
        #1;
        chk("a_pc",   64'(pc_a),   m_pc[0]);
        chk("a_seq",  64'(seq_a),  (m_pc[0] + 4) & m_mask[0]);
        chk("a_ce",   64'(ce_a),   64'(m_ce[0]));
        chk("a_pend", 64'(pend_a), 64'(m_pend[0]));
        chk("a_mis",  64'(mis_a),  64'(m_mis[0]));
        chk("b_pc",   64'(pc_b),   m_pc[1]);
        chk("b_seq",  64'(seq_b),  (m_pc[1] + 4) & m_mask[1]);
        chk("b_ce",   64'(ce_b),   64'(m_ce[1]));
        chk("b_pend", 64'(pend_b), 64'(m_pend[1]));
        chk("b_mis",  64'(mis_b),  64'(m_mis[1]));
    endtask

    initial begin
        m_mask[0] = 64'hFFFF_FFFF;
        m_mask[1] = 64'h0000_FFFF;
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = 0; m_tgt[k] = 0; m_ce[k] = 0; m_pend[k] = 0; m_mis[k] = 0;
        end
        rst = 1; stall = 0; ready = 1; br = 0; fl = 0; br_t = 0; fl_t = 0;

        // 1. reset, start-up cycle, free run
        cyc(); cyc();
        chk("t1_rst_pc", 64'(pc_a), 64'hBFC0_0000);
        chk("t1_rst_ce", 64'(ce_a), 64'd0);
        chk("t1_rst_pc_b", 64'(pc_b), 64'h0000);
        rst = 0;
        cyc();
        chk("t1_start_ce", 64'(ce_a), 64'd1);
        chk("t1_start_pc", 64'(pc_a), 64'hBFC0_0000);
        cyc(); chk("t1_pc4", 64'(pc_a), 64'hBFC0_0004);
        cyc(); chk("t1_pc8", 64'(pc_a), 64'hBFC0_0008);
        chk("t1_seq", 64'(seq_a), 64'hBFC0_000C);

        // 2. branch under stall
        br = 1; br_t = 32'h100; cyc(); br = 0;
        chk("t2_pc100", 64'(pc_a), 64'h100);
        stall = 1; br = 1; br_t = 32'h200; cyc(); br = 0;
        chk("t2_hold", 64'(pc_a), 64'h100);
        chk("t2_pend", 64'(pend_a), 64'd1);
        repeat (3) cyc();
        chk("t2_hold3", 64'(pc_a), 64'h100);
        stall = 0; cyc();
        chk("t2_redir", 64'(pc_a), 64'h200);
        chk("t2_pend0", 64'(pend_a), 64'd0);

        // 3. flush beats a pending and a live branch, even under stall
        stall = 1; br = 1; br_t = 32'h300; cyc();
        fl = 1; fl_t = 32'h8000_0180; br_t = 32'h400; cyc();
        fl = 0; br = 0;
        chk("t3_flush", 64'(pc_a), 64'h8000_0180);
        chk("t3_pend0", 64'(pend_a), 64'd0);
        stall = 0; cyc();
        chk("t3_seq", 64'(pc_a), 64'h8000_0184);

        // 4. backpressure, newer pending target overwrites older
        ready = 0; br = 1; br_t = 32'h500; cyc();
        br_t = 32'h600; cyc(); br = 0; cyc();
        chk("t4_hold", 64'(pc_a), 64'h8000_0184);
        ready = 1; cyc();
        chk("t4_newest", 64'(pc_a), 64'h600);

        // 5. wrap on the 16-bit instance, misaligned branch
        br = 1; br_t = 32'hFFFC; cyc(); br = 0;
        chk("t5_fffc", 64'(pc_b), 64'hFFFC);
        cyc();
        chk("t5_wrap", 64'(pc_b), 64'h0000);
        chk("t5_wrap_mis", 64'(mis_b), 64'd0);
        chk("t5_nowrap_a", 64'(pc_a), 64'h1_0000);
        br = 1; br_t = 32'h0102; cyc(); br = 0;
        chk("t5_mis_pc", 64'(pc_b), 64'h0102);
        chk("t5_mis", 64'(mis_b), 64'd1);
        cyc();
        chk("t5_seq_pc", 64'(pc_b), 64'h0106);
        chk("t5_mis_clr", 64'(mis_b), 64'd0);

        // 6. reset overrides flush with state pending and misaligned
        br = 1; br_t = 32'h103; cyc();
        stall = 1; br_t = 32'h700; cyc(); br = 0;
        chk("t6_pend", 64'(pend_a), 64'd1);
        chk("t6_mis", 64'(mis_a), 64'd1);
        fl = 1; fl_t = 32'h900; rst = 1; cyc();
        fl = 0; rst = 0; stall = 0;
        chk("t6_pc", 64'(pc_a), 64'hBFC0_0000);
        chk("t6_ce", 64'(ce_a), 64'd0);
        chk("t6_pend0", 64'(pend_a), 64'd0);
        chk("t6_mis0", 64'(mis_a), 64'd0);

        // Randomized phase, checked every cycle against the model
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(99) < 2);
            stall = ($urandom_range(99) < 30);
            ready = ($urandom_range(99) < 70);
            br    = ($urandom_range(99) < 25);
            fl    = ($urandom_range(99) < 6);
            br_t  = $urandom();
            fl_t  = $urandom();
            if ($urandom_range(3) == 0) br_t = 32'hFFFF_FFF0 | 32'($urandom_range(15));
            if ($urandom_range(3) == 0) br_t[15:4] = 12'hFFF;
            if ($urandom_range(1) == 0) begin
                br_t[1:0] = 2'b00;
                fl_t[1:0] = 2'b00;
            end
            cyc();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
